// File: rtl/ai_accel_pkg.sv
// Shared definitions for the AI accelerator driver and the accelerator.
// Opcodes, status codes, FSM encoding and per-op output sizing.
package ai_accel_pkg;

    localparam logic [3:0] OP_MATMUL  = 4'd0;
    localparam logic [3:0] OP_CONV2D  = 4'd1;
    localparam logic [3:0] OP_RELU    = 4'd2;
    localparam logic [3:0] OP_SOFTMAX = 4'd3;
    localparam logic [3:0] OP_POOL    = 4'd4;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ACC_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BAD_OP  = 2'b11;

    localparam logic [4:0] VEC_BYTES = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_DATA,
        S_LOAD_WGT,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_FINISH
    } state_t;

    function automatic logic op_valid(input logic [3:0] op);
        return op <= OP_POOL;
    endfunction

    function automatic logic needs_wgt(input logic [3:0] op);
        return (op == OP_MATMUL) || (op == OP_CONV2D);
    endfunction

    function automatic logic [4:0] out_count(input logic [3:0] op);
        return ((op == OP_CONV2D) || (op == OP_POOL)) ? 5'd4 : 5'd16;
    endfunction

endpackage

// File: rtl/ai_accel_mem_seq.sv
// Byte-wise memory sequencer shared by the load and store phases.
// Walks base+idx (mod 256) and tracks the one-cycle read return.
module ai_accel_mem_seq
    import ai_accel_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       we,
    input  logic [7:0] base,
    input  logic [4:0] count,
    output logic       req,
    output logic       wr,
    output logic [7:0] addr,
    output logic [3:0] idx,
    output logic       cap_valid,
    output logic [3:0] cap_idx,
    output logic       done
);

    logic [4:0] idx_q;

    assign req  = en && (idx_q < count);
    assign wr   = req && we;
    assign addr = req ? (base + {4'd0, idx_q[3:0]}) : 8'd0;
    assign idx  = idx_q[3:0];

    // Writes finish on the last strobe; reads finish when the last byte returns.
    assign done = we ? (req && (idx_q == count - 5'd1))
                     : (cap_valid && ({1'b0, cap_idx} == count - 5'd1));

    // Byte index advances per strobe; read tags trail the strobe by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= 5'd0;
            cap_valid <= 1'b0;
            cap_idx   <= 4'd0;
        end else begin
            cap_valid <= req && !we;
            cap_idx   <= idx_q[3:0];
            if (!en || done) begin
                idx_q <= 5'd0;
            end else if (req) begin
                idx_q <= idx_q + 5'd1;
            end
        end
    end

endmodule

// File: rtl/ai_accel_driver.sv
// Host-command driver for the AI accelerator: loads operands,
// starts the accelerator, waits with timeout and stores results.
module ai_accel_driver
    import ai_accel_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [7:0]   cmd_src,
    input  logic [7:0]   cmd_wgt,
    input  logic [7:0]   cmd_dst,
    output logic         mem_req,
    output logic         mem_we,
    output logic [7:0]   mem_addr,
    output logic [7:0]   mem_wdata,
    input  logic [7:0]   mem_rdata,
    output logic         acc_enable,
    output logic [3:0]   acc_operation,
    output logic [127:0] acc_data,
    output logic [127:0] acc_weights,
    input  logic [127:0] acc_result,
    input  logic         acc_done,
    input  logic         acc_error,
    output logic         busy,
    output logic         cmd_done,
    output logic [1:0]   cmd_status
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state, nxt;
    logic [3:0]     op_q;
    logic [7:0]     src_q, wgt_q, dst_q;
    logic [127:0]   res_q;
    logic [CW-1:0]  wcnt;
    logic [1:0]     st_q, st_val;
    logic           st_load, accept;
    logic           seq_en, seq_we, seq_wr, seq_done, cap_v;
    logic [7:0]     seq_base;
    logic [4:0]     seq_cnt;
    logic [3:0]     seq_idx, cap_idx;

    assign cmd_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign accept        = cmd_valid && cmd_ready;
    assign acc_enable    = (state == S_ISSUE);
    assign acc_operation = op_q;

    assign seq_en   = state inside {S_LOAD_DATA, S_LOAD_WGT, S_STORE};
    assign seq_we   = (state == S_STORE);
    assign seq_base = (state == S_LOAD_WGT) ? wgt_q :
                      (state == S_STORE)    ? dst_q : src_q;
    assign seq_cnt  = seq_we ? out_count(op_q) : VEC_BYTES;

    assign mem_we    = seq_wr;
    assign mem_wdata = seq_wr ? res_q[{seq_idx, 3'b000} +: 8] : 8'd0;

    ai_accel_mem_seq u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (seq_en),
        .we        (seq_we),
        .base      (seq_base),
        .count     (seq_cnt),
        .req       (mem_req),
        .wr        (seq_wr),
        .addr      (mem_addr),
        .idx       (seq_idx),
        .cap_valid (cap_v),
        .cap_idx   (cap_idx),
        .done      (seq_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next-state logic and status selection.
    always_comb begin
        nxt     = state;
        st_load = 1'b0;
        st_val  = ST_OK;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    st_load = 1'b1;
                    if (op_valid(cmd_op)) begin
                        nxt = S_LOAD_DATA;
                    end else begin
                        nxt    = S_FINISH;
                        st_val = ST_BAD_OP;
                    end
                end
            end
            S_LOAD_DATA: begin
                if (seq_done) nxt = needs_wgt(op_q) ? S_LOAD_WGT : S_ISSUE;
            end
            S_LOAD_WGT: begin
                if (seq_done) nxt = S_ISSUE;
            end
            S_ISSUE: nxt = S_WAIT;
            S_WAIT: begin
                if (acc_error) begin
                    nxt     = S_FINISH;
                    st_load = 1'b1;
                    st_val  = ST_ACC_ERR;
                end else if (acc_done) begin
                    nxt = S_STORE;
                end else if (wcnt == CW'(TIMEOUT - 1)) begin
                    nxt     = S_FINISH;
                    st_load = 1'b1;
                    st_val  = ST_TIMEOUT;
                end
            end
            S_STORE: begin
                if (seq_done) nxt = S_FINISH;
            end
            S_FINISH: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Command latch, operand capture and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 4'd0;
            src_q       <= 8'd0;
            wgt_q       <= 8'd0;
            dst_q       <= 8'd0;
            acc_data    <= '0;
            acc_weights <= '0;
            res_q       <= '0;
        end else if (accept) begin
            op_q        <= cmd_op;
            src_q       <= cmd_src;
            wgt_q       <= cmd_wgt;
            dst_q       <= cmd_dst;
            acc_data    <= '0;
            acc_weights <= '0;
            res_q       <= '0;
        end else begin
            if (cap_v && state == S_LOAD_DATA)
                acc_data[{cap_idx, 3'b000} +: 8] <= mem_rdata;
            if (cap_v && state == S_LOAD_WGT)
                acc_weights[{cap_idx, 3'b000} +: 8] <= mem_rdata;
            if (state == S_WAIT && acc_done && !acc_error)
                res_q <= acc_result;
        end
    end

    // Wait counter, pending status and the completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= '0;
            st_q       <= ST_OK;
            cmd_done   <= 1'b0;
            cmd_status <= ST_OK;
        end else begin
            wcnt     <= (state == S_WAIT) ? wcnt + 1'b1 : '0;
            cmd_done <= (state == S_FINISH);
            if (st_load) st_q <= st_val;
            if (state == S_FINISH) cmd_status <= st_q;
            else if (accept)       cmd_status <= ST_OK;
        end
    end

endmodule

// File: tb/tb_ai_accel_driver.sv
// Randomized scoreboard bench for ai_accel_driver with memory
// and accelerator responders and a decoupled output monitor.
module tb_ai_accel_driver;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = 4'd0;
    logic [7:0]   cmd_src = 8'd0, cmd_wgt = 8'd0, cmd_dst = 8'd0;
    logic         mem_req, mem_we;
    logic [7:0]   mem_addr, mem_wdata;
    logic [7:0]   mem_rdata = 8'd0;
    logic         acc_enable;
    logic [3:0]   acc_operation;
    logic [127:0] acc_data, acc_weights;
    logic [127:0] acc_result = '0;
    logic         acc_done = 1'b0, acc_error = 1'b0;
    logic         busy, cmd_done;
    logic [1:0]   cmd_status;

    ai_accel_driver #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_wgt(cmd_wgt), .cmd_dst(cmd_dst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .acc_enable(acc_enable), .acc_operation(acc_operation),
        .acc_data(acc_data), .acc_weights(acc_weights),
        .acc_result(acc_result), .acc_done(acc_done), .acc_error(acc_error),
        .busy(busy), .cmd_done(cmd_done), .cmd_status(cmd_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [1:0]   st;
        logic [7:0]   dst;
        logic [127:0] data, wgt, res;
        int           nw, lat, nen;
        bit           abort;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   rd_q[$];
    logic [15:0]  wr_log[$];
    int           checks = 0, failures = 0;
    int           cyc = 0;
    logic [7:0]   mem [256];
    int           mode = 0, dly = 1;
    bit           spur = 1'b0;
    int           en_cnt = 0;
    logic [127:0] c_data = '0, c_wgt = '0;
    logic [3:0]   c_op = 4'd0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Accelerator behaviour: RELU clamps negatives, others mix operands.
    function automatic logic [127:0] accel_fn(input logic [3:0] op,
        input logic [127:0] d, input logic [127:0] w);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            if (op == 4'd2) r[8*i +: 8] = d[8*i+7] ? 8'd0 : d[8*i +: 8];
            else r[8*i +: 8] = d[8*i +: 8] + w[8*i +: 8] + {4'd0, op};
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: read data returns during the cycle after the strobe.
    initial begin
        bit         pend = 1'b0;
        logic [7:0] pend_a = 8'd0;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 16; a++) mem[16 + a] = 8'(a);
        mem[8'h13] = 8'h85;
        forever begin
            @(negedge clk);
            mem_rdata = pend ? mem[pend_a] : 8'($urandom);
            pend = rst_n && mem_req && !mem_we;
            pend_a = mem_addr;
            if (rst_n && mem_req && mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    // Accelerator responder.
    initial begin
        int cd = 0;
        forever begin
            @(negedge clk);
            acc_done = 1'b0;
            acc_error = 1'b0;
            if (!rst_n) begin
                cd = 0;
            end else begin
                if (spur) begin
                    acc_done = 1'b1;
                    acc_error = 1'b1;
                end
                if (acc_enable) begin
                    en_cnt++;
                    c_data = acc_data;
                    c_wgt = acc_weights;
                    c_op = acc_operation;
                    cd = (mode == 2) ? 0 : dly;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        if (mode == 1) begin
                            acc_error = 1'b1;
                            acc_done = 1'($urandom_range(0, 1));
                        end else begin
                            acc_done = 1'b1;
                            acc_result = accel_fn(c_op, c_data, c_wgt);
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the expected record whenever the DUT completes.
    initial begin
        int   acc_cyc = 0, en_base = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_ctl", 128'({cmd_ready, busy, cmd_done, cmd_status,
                    mem_req, mem_we, acc_enable, acc_operation}),
                    128'({1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0}));
                chk("reset_mem", 128'({mem_addr, mem_wdata}), 128'(0));
                chk("reset_vec", acc_data | acc_weights, '0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("abort_flag", 128'(e.abort), 128'(1));
                    chk("abort_nwr", 128'(wr_log.size()), 128'(e.nw));
                    for (int i = 0; i < wr_log.size() && i < e.nw; i++)
                        chk("abort_wr", 128'(wr_log[i]),
                            128'({e.dst + 8'(i), e.res[8*i +: 8]}));
                    chk("abort_rd_left", 128'(rd_q.size()), 128'(0));
                end
                wr_log.delete();
                rd_q.delete();
            end else begin
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc;
                    en_base = en_cnt;
                    wr_log.delete();
                end
                if (mem_req) chk("req_busy", 128'(busy), 128'(1));
                if (mem_req && !mem_we) begin
                    if (rd_q.size() == 0) chk("rd_unexp", 128'(mem_addr), 128'(1'bx));
                    else chk("rd_addr", 128'(mem_addr), 128'(rd_q.pop_front()));
                end
                if (mem_req && mem_we) wr_log.push_back({mem_addr, mem_wdata});
                if (cmd_done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexp", 128'(cmd_done), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("abort_flag", 128'(e.abort), 128'(0));
                        chk("status", 128'(cmd_status), 128'(e.st));
                        chk("latency", 128'(cyc - acc_cyc), 128'(e.lat));
                        chk("enables", 128'(en_cnt - en_base), 128'(e.nen));
                        if (e.nen > 0) begin
                            chk("acc_op", 128'(c_op), 128'(e.op));
                            chk("acc_data", c_data, e.data);
                            chk("acc_wgt", c_wgt, e.wgt);
                        end
                        chk("n_writes", 128'(wr_log.size()), 128'(e.nw));
                        for (int i = 0; i < wr_log.size() && i < e.nw; i++)
                            chk("write", 128'(wr_log[i]),
                                128'({e.dst + 8'(i), e.res[8*i +: 8]}));
                        chk("rd_left", 128'(rd_q.size()), 128'(0));
                    end
                    wr_log.delete();
                    rd_q.delete();
                end
            end
        end
    end

    // Issue one command and push its expected outcome.
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] src,
        input logic [7:0] wgt, input logic [7:0] dst, input int md,
        input int d, input bit abort);
        exp_t e;
        bit   good = (op <= 4'd4);
        bit   w = (op <= 4'd1);
        int   n = (op == 4'd1 || op == 4'd4) ? 4 : 16;
        int   base = 20 + (w ? 17 : 0);
        bit   hit = 1'b0;
        e.op = op; e.dst = dst; e.abort = abort;
        e.data = '0; e.wgt = '0;
        if (good) begin
            for (int i = 0; i < 16; i++) begin
                e.data[8*i +: 8] = mem[src + 8'(i)];
                rd_q.push_back(src + 8'(i));
            end
            if (w) for (int i = 0; i < 16; i++) begin
                e.wgt[8*i +: 8] = mem[wgt + 8'(i)];
                rd_q.push_back(wgt + 8'(i));
            end
        end
        e.res = accel_fn(op, e.data, e.wgt);
        if (!good) begin
            e.st = 2'b11; e.nw = 0; e.nen = 0; e.lat = 2;
        end else begin
            e.nen = 1;
            case (md)
                0: begin e.st = 2'b00; e.nw = n; e.lat = base + d + n; end
                1: begin e.st = 2'b01; e.nw = 0; e.lat = base + d; end
                default: begin e.st = 2'b10; e.nw = 0; e.lat = base + TO; end
            endcase
        end
        if (abort) e.nw = 6;
        mode = md;
        dly = d;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op;
        cmd_src = src; cmd_wgt = wgt; cmd_dst = dst;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom); cmd_src = 8'($urandom);
        if (abort) begin
            for (int c = 0; c < 2000 && !hit; c++) begin
                @(negedge clk); #1;
                hit = mem_req && mem_we && (mem_addr == dst + 8'd5);
            end
            if (!hit) begin
                checks++; failures++;
                $display("FAIL abort_wait got=none want=write_byte5");
            end
            rst_n = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("ready_after_rst", 128'(cmd_ready), 128'(1));
        end
        for (int c = 0; c < 2000 && exp_q.size() > 0; c++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL cmd_timeout got=pending want=done op=%0d", op);
            exp_q.delete();
            rd_q.delete();
        end
    endtask

    initial begin
        int sel, md;
        logic [3:0] op;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_cmd(4'd2, 8'h10, 8'h00, 8'h80, 0, 3, 1'b0);
        run_cmd(4'd1, 8'h22, 8'h40, 8'hA0, 0, 2, 1'b0);
        run_cmd(4'd0, 8'hF8, 8'h57, 8'hC0, 0, 1, 1'b0);
        run_cmd(4'd7, 8'h00, 8'h00, 8'h00, 0, 1, 1'b0);
        run_cmd(4'd3, 8'h30, 8'h00, 8'h90, 2, 1, 1'b0);
        run_cmd(4'd4, 8'h31, 8'h00, 8'h98, 1, 4, 1'b0);
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        repeat (4) @(posedge clk);
        run_cmd(4'd0, 8'h60, 8'h70, 8'hD0, 0, 2, 1'b1);
        run_cmd(4'd3, 8'h61, 8'h00, 8'hE0, 0, 2, 1'b0);
        for (int k = 0; k < 25; k++) begin
            sel = $urandom_range(0, 9);
            op = (sel <= 4) ? 4'(sel) : 4'($urandom_range(5, 15));
            sel = $urandom_range(0, 5);
            md = (sel <= 3) ? 0 : (sel == 4) ? 1 : 2;
            run_cmd(op, 8'($urandom), 8'($urandom), 8'($urandom), md,
                    $urandom_range(1, 5), 1'b0);
        end
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ai_accel_driver.md
AI_ACCEL_DRIVER -- requirements
Module: ai_accel_driver

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles spent waiting for the accelerator's done/error response.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  host command present.
REQ-005 cmd_ready  out  1  driver can accept a command; high only in IDLE.
REQ-006 cmd_op  in  4  opcode: 0=MATMUL, 1=CONV2D, 2=RELU, 3=SOFTMAX, 4=POOL.
REQ-007 cmd_src / cmd_wgt / cmd_dst  in  8 each  byte base addresses for data, weights and results.
REQ-008 mem_req  out  1  memory access strobe.
REQ-009 mem_we  out  1  1=write, 0=read.
REQ-010 mem_addr  out  8  byte address.
REQ-011 mem_wdata  out  8  write data.
REQ-012 mem_rdata  in  8  read data, valid exactly one cycle after the read strobe.
REQ-013 acc_enable  out  1  one-cycle start pulse to the accelerator.
REQ-014 acc_operation  out  4  opcode presented to the accelerator.
REQ-015 acc_data / acc_weights  out  128 each  16 bytes; byte i occupies bits [8i+7:8i].
REQ-016 acc_result  in  128  accelerator outputs; same byte packing.
REQ-017 acc_done / acc_error  in  1 each  accelerator completion and error.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 cmd_done  out  1  one-cycle completion pulse.
REQ-020 cmd_status  out  2  00=OK, 01=accelerator error, 10=timeout, 11=bad opcode.

Function
REQ-021 FSM states: IDLE, LOAD_DATA, LOAD_WGT, ISSUE, WAIT, STORE, FINISH.
REQ-022 Command acceptance: accepted when cmd_valid && cmd_ready; op and addresses are latched that cycle.
REQ-023 Bad opcode: cmd_op > 4 goes IDLE -> FINISH with status 11; no memory access and no acc_enable.
REQ-024 LOAD_DATA: one read per cycle at cmd_src+i, i=0..15, address wrapping mod 256.
REQ-025 Read capture: mem_rdata is captured into acc_data byte i one cycle after request i; a 16-byte load takes 17 cycles.
REQ-026 LOAD_WGT: entered only for MATMUL/CONV2D, with the same rules as LOAD_DATA at cmd_wgt; for other ops acc_weights is all-zero.
REQ-027 ISSUE: acc_enable=1 for exactly one cycle with acc_operation=latched op; acc_data/acc_weights stay stable from ISSUE until FINISH.
REQ-028 WAIT, success: a cycle counter starts at 0 on WAIT entry; acc_done=1 && acc_error=0 captures acc_result and moves to STORE.
REQ-029 WAIT, error: acc_error=1 (with or without acc_done) moves to FINISH with status 01; no store.
REQ-030 WAIT, timeout: counter reaching TIMEOUT with neither input moves to FINISH with status 10.
REQ-031 STORE: one write per cycle (mem_we=1), byte i of the captured result to cmd_dst+i, mod 256.
REQ-032 Store count: N=16 for MATMUL/RELU/SOFTMAX; N=4 for CONV2D/POOL.
REQ-033 FINISH: cmd_done=1 for one cycle, then IDLE.
REQ-034 Status hold: cmd_status is held until the next command is accepted.
REQ-035 Strobe discipline: mem_req=0 outside LOAD/STORE; mem_we=0 during loads.
REQ-036 Idle robustness: acc_done/acc_error arriving outside WAIT are ignored; cmd_valid outside IDLE is not accepted.

Reset
REQ-037 Reset values: rst_n low asynchronously forces IDLE and clears all counters and capture registers.
REQ-038 Output reset values: cmd_ready=1, busy=0, cmd_done=0, cmd_status=00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, acc_enable=0, acc_operation=0, acc_data=0, acc_weights=0.
REQ-039 Reset mid-command: reset during any state aborts the command with no further memory writes and no cmd_done pulse.

Structure
REQ-040 Package: a shared package ai_accel_pkg holds the opcode constants, status codes, FSM state encoding, and per-op output count (16/4), shared with the accelerator.
REQ-041 Sub-module: one sub-module, ai_accel_mem_seq, holds the address counter, the one-cycle read-capture pipeline, and the byte index; it is used by both load and store phases.

Verification
REQ-042 RELU scenario: src=0x10 holds 0x00..0x0F, then 0x85 at 0x13; responder returns done after 3 cycles, result = input with byte3=0x00; dst=0x80 gets 16 writes; status 00; exactly one acc_enable pulse.
REQ-043 CONV2D scenario: wgt=0x40 loaded, weights bytes 9..15 hold the values read from memory; exactly 4 writes to dst..dst+3; LOAD_WGT occurs; status 00.
REQ-044 Wrap-around scenario: src=0xF8 reads addresses 0xF8..0xFF then 0x00..0x07 in order.
REQ-045 Bad opcode scenario: cmd_op=7 gives cmd_done two cycles after acceptance with status 11, zero mem_req, zero acc_enable.
REQ-046 Timeout scenario: TIMEOUT=8 with a silent accelerator gives status 10 with no writes; acc_error=1 in WAIT gives status 01 with no writes.
REQ-047 Reset scenario: rst_n pulsed low during STORE of byte 5 stops writes immediately; cmd_ready=1 after release; the next command runs normally.
